// File: rtl/pattern_serializer.sv
// pattern_serializer: shifts a latched pattern out MSB-first, repeat_cnt times, with gap idle cycles between frames
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   start, abort       transfer request (taken only in IDLE) and synchronous cancel
//   pattern            bits to send, bit PAT_W-1 first
//   repeat_cnt         number of frames, 0 means none
//   gap                idle cycles between consecutive frames
//   ready              high only in IDLE
//   serial_out         current bit, 0 whenever out_valid is low
//   out_valid          serial_out carries a pattern bit
//   frame_start        first bit of each frame
//   done               one-cycle pulse after a normal completion
module pattern_serializer #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  output logic             ready,
  output logic             serial_out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             done
);
  localparam int IW = $clog2(PAT_W);
  localparam logic [IW-1:0] TOP = IW'(PAT_W - 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [CNT_W-1:0] r_cnt;
  logic [GAP_W-1:0] r_gap, r_gcnt;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    w_nidx;
  assign w_nidx = r_idx - 1'b1;
  // r_idx is the index of the bit currently on serial_out; r_cnt counts frames left including the current one
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pat       <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_gcnt      <= '0;
      r_idx       <= '0;
      ready       <= 1'b1;
      serial_out  <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else if (abort && r_state != IDLE) begin
      r_state     <= IDLE;
      ready       <= 1'b1;
      serial_out  <= 1'b0;
      out_valid   <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start && !abort) begin
          r_pat <= pattern;
          r_cnt <= repeat_cnt;
          r_gap <= gap;
          r_idx <= TOP;
          ready <= 1'b0;
          if (repeat_cnt != '0) begin
            r_state     <= SEND;
            serial_out  <= pattern[PAT_W-1];
            out_valid   <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            r_state <= DONE;
            done    <= 1'b1;
          end
        end
        SEND: if (r_idx != '0) begin
          r_idx       <= w_nidx;
          serial_out  <= r_pat[w_nidx];
          frame_start <= 1'b0;
        end else if (r_cnt == CNT_W'(1)) begin
          r_state     <= DONE;
          serial_out  <= 1'b0;
          out_valid   <= 1'b0;
          frame_start <= 1'b0;
          done        <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
          r_idx <= TOP;
          if (r_gap != '0) begin
            r_state     <= GAP;
            r_gcnt      <= r_gap;
            serial_out  <= 1'b0;
            out_valid   <= 1'b0;
            frame_start <= 1'b0;
          end else begin
            serial_out  <= r_pat[PAT_W-1];
            frame_start <= 1'b1;
          end
        end
        GAP: if (r_gcnt == GAP_W'(1)) begin
          r_state     <= SEND;
          serial_out  <= r_pat[PAT_W-1];
          out_valid   <= 1'b1;
          frame_start <= 1'b1;
        end else begin
          r_gcnt <= r_gcnt - 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          done    <= 1'b0;
          ready   <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_serializer.sv
// tb_pattern_serializer: directed checks of pattern_serializer output sequences
module tb_pattern_serializer;
  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [3:0] pattern;
  logic [7:0] repeat_cnt;
  logic [3:0] gap;
  logic       ready, serial_out, out_valid, frame_start, done;
  logic [4:0] obs;
  int         vectors = 0;
  int         errors = 0;
  pattern_serializer #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .repeat_cnt(repeat_cnt), .gap(gap),
    .ready(ready), .serial_out(serial_out), .out_valid(out_valid),
    .frame_start(frame_start), .done(done)
  );
  always #5 clk = ~clk;
  // {ready, out_valid, serial_out, frame_start, done}
  assign obs = {ready, out_valid, serial_out, frame_start, done};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic launch(input logic [3:0] p, input logic [7:0] r, input logic [3:0] g);
    pattern = p;
    repeat_cnt = r;
    gap = g;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pattern = 4'h0;
    repeat_cnt = 8'd0;
    gap = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    vectors++;
    if (obs !== 5'b10000) begin
      errors++;
      $display("FAIL reset: got %b want %b", obs, 5'b10000);
    end
    tick();
  endtask
  task automatic test_gap0;
    logic [4:0] exp [10] = '{5'b01110, 5'b01000, 5'b01100, 5'b01000, 5'b01110,
                             5'b01000, 5'b01100, 5'b01000, 5'b00001, 5'b10000};
    logic [3:0] hist = 4'b0000;
    int hits = 0;
    launch(4'b1010, 8'd2, 4'd0);
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL gap0 T+%0d: got %b want %b", i + 1, obs, exp[i]);
      end
      if (out_valid) begin
        hist = {hist[2:0], serial_out};
        if (hist == 4'b1010) hits++;
      end
      if (i < 9) tick();
    end
    vectors++;
    if (hits !== 3) begin
      errors++;
      $display("FAIL detector_hits: got %0d want 3", hits);
    end
  endtask
  task automatic test_gap2;
    logic [4:0] exp [12] = '{5'b01110, 5'b01100, 5'b01000, 5'b01100, 5'b00000, 5'b00000,
                             5'b01110, 5'b01100, 5'b01000, 5'b01100, 5'b00001, 5'b10000};
    launch(4'b1101, 8'd2, 4'd2);
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL gap2 T+%0d: got %b want %b", i + 1, obs, exp[i]);
      end
      if (i < 11) tick();
    end
  endtask
  task automatic test_zero;
    logic [4:0] exp [2] = '{5'b00001, 5'b10000};
    launch(4'b1111, 8'd0, 4'd3);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL zero T+%0d: got %b want %b", i + 1, obs, exp[i]);
      end
      if (i < 1) tick();
    end
  endtask
  task automatic test_cancel(input bit use_reset);
    launch(4'b1010, 8'd3, 4'd0);
    tick();
    tick();
    vectors++;
    if (obs !== 5'b01100) begin
      errors++;
      $display("FAIL cancel%0d T+3: got %b want %b", use_reset, obs, 5'b01100);
    end
    if (use_reset) reset = 1'b1;
    else abort = 1'b1;
    tick();
    reset = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (obs !== 5'b10000) begin
        errors++;
        $display("FAIL cancel%0d T+%0d: got %b want %b", use_reset, i + 4, obs, 5'b10000);
      end
      tick();
    end
  endtask
  task automatic test_back_to_back;
    logic [4:0] exp [7] = '{5'b01110, 5'b01000, 5'b01100, 5'b01000, 5'b00001, 5'b10000, 5'b10000};
    launch(4'b1010, 8'd1, 4'd0);
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL ignored_start T+%0d: got %b want %b", i + 1, obs, exp[i]);
      end
      if (i == 1) begin
        pattern = 4'b1111;
        start = 1'b1;
      end else begin
        start = 1'b0;
        if (i == 2) pattern = 4'b0101;
      end
      if (i < 6) tick();
    end
    start = 1'b0;
  endtask
  task automatic test_abort_start;
    logic [4:0] exp [6] = '{5'b01110, 5'b01000, 5'b01100, 5'b01000, 5'b00001, 5'b10000};
    pattern = 4'b1111;
    repeat_cnt = 8'd1;
    gap = 4'd0;
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (obs !== 5'b10000) begin
      errors++;
      $display("FAIL abort_start T+1: got %b want %b", obs, 5'b10000);
    end
    launch(4'b1010, 8'd1, 4'd0);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL after_abort T+%0d: got %b want %b", i + 2, obs, exp[i]);
      end
      if (i < 5) tick();
    end
  endtask
  initial begin
    test_reset();
    test_gap0();
    test_gap2();
    test_zero();
    tick();
    test_cancel(1'b0);
    test_cancel(1'b1);
    test_back_to_back();
    test_abort_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
